eth_header_arb: RTL and testbench

Parametrised N-channel arbiter for Ethernet header beats (valid/ready, src_mac, dest_mac, eth_type). It merges headers from N producer channels into one consumer stream through a single-entry registered output stage and tags each header with its source channel. Arbitration is round-robin or fixed-priority, set by parameter. It sits between several header producers (for example ARP, IPv4 and raw TX paths) and the single Ethernet frame transmitter.

---
 rtl/eth_header_arb.sv | 113 +++++++++++
 tb/tb_eth_header_arb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_header_arb.sv
// N-channel Ethernet header arbiter: round-robin or fixed-priority grant into a
// single registered output stage, with each header tagged by its source channel.
module eth_header_arb #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned FIXED_PRIO = 0,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     in_valid_i,
    output logic [NUM_CH-1:0]     in_ready_o,
    input  logic [48*NUM_CH-1:0]  in_src_mac_i,
    input  logic [48*NUM_CH-1:0]  in_dest_mac_i,
    input  logic [16*NUM_CH-1:0]  in_eth_type_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [47:0]           out_src_mac_o,
    output logic [47:0]           out_dest_mac_o,
    output logic [15:0]           out_eth_type_o,
    output logic [CH_W-1:0]       out_chan_o
);

    logic              load_en;
    logic              found;
    logic              accept;
    logic [NUM_CH-1:0] gnt_oh;
    logic [CH_W-1:0]   gnt_idx;
    logic [47:0]       gnt_src;
    logic [47:0]       gnt_dst;
    logic [15:0]       gnt_type;

    logic              out_valid_q, out_valid_d;
    logic [47:0]       out_src_q, out_src_d;
    logic [47:0]       out_dst_q, out_dst_d;
    logic [15:0]       out_type_q, out_type_d;
    logic [CH_W-1:0]   out_chan_q, out_chan_d;
    logic [CH_W-1:0]   last_grant_q, last_grant_d;

    assign load_en = !out_valid_q || out_ready_i;

    // Pass 0 only considers channels above last_grant (round-robin); pass 1 scans
    // from channel 0, which covers the wrap and is the whole search in fixed mode.
    always_comb begin
        found    = 1'b0;
        gnt_oh   = '0;
        gnt_idx  = '0;
        gnt_src  = '0;
        gnt_dst  = '0;
        gnt_type = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (!found && in_valid_i[i] &&
                    (pass == 1 || (FIXED_PRIO == 0 && i > int'(last_grant_q)))) begin
                    found     = 1'b1;
                    gnt_oh[i] = 1'b1;
                    gnt_idx   = CH_W'(i);
                    gnt_src   = in_src_mac_i[48*i +: 48];
                    gnt_dst   = in_dest_mac_i[48*i +: 48];
                    gnt_type  = in_eth_type_i[16*i +: 16];
                end
            end
        end
    end

    assign accept     = load_en && found && rst_n;
    assign in_ready_o = (load_en && rst_n) ? gnt_oh : '0;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_src_d    = out_src_q;
        out_dst_d    = out_dst_q;
        out_type_d   = out_type_q;
        out_chan_d   = out_chan_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_src_d   = gnt_src;
            out_dst_d   = gnt_dst;
            out_type_d  = gnt_type;
            out_chan_d  = gnt_idx;
            if (FIXED_PRIO == 0) begin
                last_grant_d = gnt_idx;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_src_q    <= '0;
            out_dst_q    <= '0;
            out_type_q   <= '0;
            out_chan_q   <= '0;
            last_grant_q <= CH_W'(NUM_CH - 1);
        end else begin
            out_valid_q  <= out_valid_d;
            out_src_q    <= out_src_d;
            out_dst_q    <= out_dst_d;
            out_type_q   <= out_type_d;
            out_chan_q   <= out_chan_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_src_mac_o  = out_src_q;
    assign out_dest_mac_o = out_dst_q;
    assign out_eth_type_o = out_type_q;
    assign out_chan_o     = out_chan_q;

endmodule

// File: tb/tb_eth_header_arb.sv
// Directed bench for eth_header_arb: round-robin x4, fixed-priority x4,
// round-robin x3 wrap cases and the single-channel register slice.
module tb_eth_header_arb;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Round-robin, 4 channels
    logic [3:0]   a_valid, a_ready;
    logic [191:0] a_src, a_dst;
    logic [63:0]  a_type;
    logic         a_ovalid, a_oready;
    logic [47:0]  a_osrc, a_odst;
    logic [15:0]  a_otype;
    logic [1:0]   a_ochan;

    // Fixed priority, 4 channels
    logic [3:0]   f_valid, f_ready;
    logic [191:0] f_src, f_dst;
    logic [63:0]  f_type;
    logic         f_ovalid, f_oready;
    logic [47:0]  f_osrc, f_odst;
    logic [15:0]  f_otype;
    logic [1:0]   f_ochan;

    // Round-robin, 3 channels
    logic [2:0]   t_valid, t_ready;
    logic [143:0] t_src, t_dst;
    logic [47:0]  t_type;
    logic         t_ovalid, t_oready;
    logic [47:0]  t_osrc, t_odst;
    logic [15:0]  t_otype;
    logic [1:0]   t_ochan;

    // Single channel
    logic [0:0]   s_valid, s_ready;
    logic [47:0]  s_src, s_dst;
    logic [15:0]  s_type;
    logic         s_ovalid, s_oready;
    logic [47:0]  s_osrc, s_odst;
    logic [15:0]  s_otype;
    logic [0:0]   s_ochan;

    eth_header_arb #(.NUM_CH(4), .FIXED_PRIO(0)) u_rr4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(a_valid), .in_ready_o(a_ready),
        .in_src_mac_i(a_src), .in_dest_mac_i(a_dst), .in_eth_type_i(a_type),
        .out_valid_o(a_ovalid), .out_ready_i(a_oready),
        .out_src_mac_o(a_osrc), .out_dest_mac_o(a_odst), .out_eth_type_o(a_otype),
        .out_chan_o(a_ochan)
    );

    eth_header_arb #(.NUM_CH(4), .FIXED_PRIO(1)) u_fp4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(f_valid), .in_ready_o(f_ready),
        .in_src_mac_i(f_src), .in_dest_mac_i(f_dst), .in_eth_type_i(f_type),
        .out_valid_o(f_ovalid), .out_ready_i(f_oready),
        .out_src_mac_o(f_osrc), .out_dest_mac_o(f_odst), .out_eth_type_o(f_otype),
        .out_chan_o(f_ochan)
    );

    eth_header_arb #(.NUM_CH(3), .FIXED_PRIO(0)) u_rr3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(t_valid), .in_ready_o(t_ready),
        .in_src_mac_i(t_src), .in_dest_mac_i(t_dst), .in_eth_type_i(t_type),
        .out_valid_o(t_ovalid), .out_ready_i(t_oready),
        .out_src_mac_o(t_osrc), .out_dest_mac_o(t_odst), .out_eth_type_o(t_otype),
        .out_chan_o(t_ochan)
    );

    eth_header_arb #(.NUM_CH(1), .FIXED_PRIO(0)) u_one (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(s_valid), .in_ready_o(s_ready),
        .in_src_mac_i(s_src), .in_dest_mac_i(s_dst), .in_eth_type_i(s_type),
        .out_valid_o(s_ovalid), .out_ready_i(s_oready),
        .out_src_mac_o(s_osrc), .out_dest_mac_o(s_odst), .out_eth_type_o(s_otype),
        .out_chan_o(s_ochan)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_rr[6];
        int exp_rst[4];
        exp_rr  = '{3, 0, 1, 2, 3, 0};
        exp_rst = '{0, 1, 2, 3};

        for (int i = 0; i < 4; i++) begin
            a_src[48*i +: 48]  = {40'h02_0000_0000, 8'(i)};
            a_dst[48*i +: 48]  = (i == 2) ? 48'hFFFF_FFFF_FFFF : {40'hAA_0000_0000, 8'(i)};
            a_type[16*i +: 16] = (i == 2) ? 16'h0806 : 16'h0800 + 16'(i);
        end
        f_src = a_src;
        f_dst = a_dst;
        f_type = a_type;
        t_src = a_src[143:0];
        t_dst = a_dst[143:0];
        for (int i = 0; i < 3; i++) t_type[16*i +: 16] = 16'h1000 + 16'(i);
        s_src = 48'h0011_2233_4455;
        s_dst = 48'h6677_8899_AABB;
        s_type = 16'h86DD;
        a_valid = '0; f_valid = '0; t_valid = '0; s_valid = '0;
        a_oready = 1'b1; f_oready = 1'b1; t_oready = 1'b1; s_oready = 1'b1;

        // Reset state
        #1;
        chk("rst_valid", a_ovalid, 0);
        chk("rst_chan", a_ochan, 0);
        chk("rst_src", a_osrc, 0);
        chk("rst_ready", a_ready, 0);
        #10 rst_n = 1'b1;
        tick();
        chk("idle_valid", a_ovalid, 0);
        chk("idle_ready", a_ready, 0);

        // Single header from channel 2
        a_valid = 4'b0100;
        #1 chk("single_ready", a_ready, 4'b0100);
        tick();
        a_valid = '0;
        chk("single_valid", a_ovalid, 1);
        chk("single_src", a_osrc, 48'h0200_0000_0002);
        chk("single_dst", a_odst, 48'hFFFF_FFFF_FFFF);
        chk("single_type", a_otype, 16'h0806);
        chk("single_chan", a_ochan, 2);
        tick();
        chk("single_drop", a_ovalid, 0);
        chk("single_hold_type", a_otype, 16'h0806);

        // Round-robin continuing after last grant = 2
        a_valid = 4'hF;
        #1 chk("rr_first_ready", a_ready, 4'b1000);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_chan", a_ochan, 64'(exp_rr[k]));
            chk("rr_src", a_osrc, {40'h02_0000_0000, 8'(exp_rr[k])});
            chk("rr_valid", a_ovalid, 1);
        end

        // Back-pressure with all channels pending
        a_oready = 1'b0;
        #1 chk("bp_ready_now", a_ready, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_valid", a_ovalid, 1);
            chk("bp_chan", a_ochan, 0);
            chk("bp_src", a_osrc, 48'h0200_0000_0000);
            chk("bp_ready", a_ready, 0);
        end
        a_oready = 1'b1;
        #1 chk("bp_release_ready", a_ready, 4'b0010);
        tick();
        chk("bp_next_chan", a_ochan, 1);
        chk("bp_next_valid", a_ovalid, 1);

        // Asynchronous reset mid-stream
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", a_ovalid, 0);
        chk("mrst_src", a_osrc, 0);
        chk("mrst_dst", a_odst, 0);
        chk("mrst_type", a_otype, 0);
        chk("mrst_chan", a_ochan, 0);
        chk("mrst_ready", a_ready, 0);
        a_valid = '0;
        #3 rst_n = 1'b1;
        tick();
        chk("mrst_idle_valid", a_ovalid, 0);
        chk("mrst_idle_ready", a_ready, 0);
        a_valid = 4'hF;
        #1 chk("rr0_ready", a_ready, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr0_chan", a_ochan, 64'(exp_rst[k]));
        end
        a_valid = '0;
        tick();
        chk("rr0_drain", a_ovalid, 0);

        // Fixed priority: ch0 starves ch3 until it drops
        f_valid = 4'b1001;
        #1 chk("fp_ready", f_ready, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fp_chan", f_ochan, 0);
            chk("fp_ready_beat", f_ready, 4'b0001);
        end
        f_valid = 4'b1000;
        #1 chk("fp_ch3_ready", f_ready, 4'b1000);
        tick();
        chk("fp_ch3_chan", f_ochan, 3);
        chk("fp_ch3_type", f_otype, 16'h0803);
        f_valid = '0;
        tick();
        chk("fp_drain", f_ovalid, 0);

        // Three channels: wrap-around cases
        t_valid = 3'b100;
        #1 chk("w_ready_a", t_ready, 3'b100);
        tick();
        chk("w_chan_a", t_ochan, 2);
        t_valid = 3'b011;
        #1 chk("w_ready_b", t_ready, 3'b001);
        tick();
        chk("w_chan_b", t_ochan, 0);
        chk("w_type_b", t_otype, 16'h1000);
        t_valid = 3'b101;
        #1 chk("w_ready_c", t_ready, 3'b100);
        tick();
        chk("w_chan_c", t_ochan, 2);
        t_valid = 3'b100;
        #1 chk("w_ready_d", t_ready, 3'b100);
        tick();
        chk("w_chan_d", t_ochan, 2);
        chk("w_type_d", t_otype, 16'h1002);
        t_valid = '0;
        tick();
        chk("w_drain", t_ovalid, 0);

        // Single-channel register slice
        s_valid = 1'b1;
        #1;
        chk("one_ready", s_ready, 1);
        chk("one_pre_valid", s_ovalid, 0);
        tick();
        chk("one_valid", s_ovalid, 1);
        chk("one_src", s_osrc, 48'h0011_2233_4455);
        chk("one_dst", s_odst, 48'h6677_8899_AABB);
        chk("one_type", s_otype, 16'h86DD);
        chk("one_chan", s_ochan, 0);
        s_oready = 1'b0;
        #1 chk("one_bp_ready", s_ready, 0);
        tick();
        chk("one_bp_valid", s_ovalid, 1);
        chk("one_bp_src", s_osrc, 48'h0011_2233_4455);
        s_valid = 1'b0;
        s_oready = 1'b1;
        tick();
        chk("one_drain", s_ovalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
